// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks the program ROM one byte per cycle, assembles 1-3 byte
// instructions and offers each to decode over a valid/ready handshake; accepts PC redirects.
module fetch_unit #(
  parameter int unsigned           ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [7:0]            instr_opcode,
  output logic [7:0]            instr_op1,
  output logic [7:0]            instr_op2,
  output logic [1:0]            instr_len,
  output logic [ADDR_WIDTH-1:0] instr_pc
);

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 2;

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_B1 = 2'd1,
    FETCH_B2 = 2'd2,
    HOLD     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_W-1:0]     opcode_q, opcode_d;
  logic [DATA_W-1:0]     op1_q, op1_d;
  logic [DATA_W-1:0]     op2_q, op2_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [ADDR_WIDTH-1:0] ipc_q, ipc_d;
  logic                  valid_q, valid_d;
  logic [LEN_W-1:0]      rom_len;

  // Instruction length is encoded in the two top opcode bits.
  function automatic logic [LEN_W-1:0] len_of(input logic [DATA_W-1:0] op);
    case (op[7:6])
      2'b00:   len_of = LEN_W'(1);
      2'b01:   len_of = LEN_W'(2);
      default: len_of = LEN_W'(3);
    endcase
  endfunction

  assign rom_len = len_of(rom_data);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH_OP;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect restarts the fetch from any state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: state_d = (rom_len == LEN_W'(1)) ? HOLD : FETCH_B1;
        FETCH_B1: state_d = (len_q == LEN_W'(2)) ? HOLD : FETCH_B2;
        FETCH_B2: state_d = HOLD;
        HOLD:     state_d = instr_ready ? FETCH_OP : HOLD;
        default:  state_d = FETCH_OP;
      endcase
    end
  end

  // Datapath / output next values; valid rises on the edge that latches the last byte
  always_comb begin
    pc_d     = pc_q;
    opcode_d = opcode_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    len_d    = len_q;
    ipc_d    = ipc_q;
    valid_d  = valid_q;
    if (redirect_valid) begin
      pc_d    = redirect_addr;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        FETCH_OP: begin
          opcode_d = rom_data;
          op1_d    = '0;
          op2_d    = '0;
          len_d    = rom_len;
          ipc_d    = pc_q;
          pc_d     = pc_q + ADDR_WIDTH'(1);
          valid_d  = (rom_len == LEN_W'(1));
        end
        FETCH_B1: begin
          op1_d   = rom_data;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          valid_d = (len_q == LEN_W'(2));
        end
        FETCH_B2: begin
          op2_d   = rom_data;
          pc_d    = pc_q + ADDR_WIDTH'(1);
          valid_d = 1'b1;
        end
        HOLD: begin
          if (instr_ready) valid_d = 1'b0;
        end
        default: valid_d = 1'b0;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RESET_VECTOR;
      opcode_q <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      len_q    <= '0;
      ipc_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      opcode_q <= opcode_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      len_q    <= len_d;
      ipc_q    <= ipc_d;
      valid_q  <= valid_d;
    end
  end

  assign rom_addr     = pc_q;
  assign instr_valid  = valid_q;
  assign instr_opcode = opcode_q;
  assign instr_op1    = op1_q;
  assign instr_op2    = op2_q;
  assign instr_len    = len_q;
  assign instr_pc     = ipc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: combinational ROM model, hand-computed expected values.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        redirect_valid;
  logic [15:0] redirect_addr;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [7:0]  instr_op1;
  logic [7:0]  instr_op2;
  logic [1:0]  instr_len;
  logic [15:0] instr_pc;

  logic [7:0]  rom [0:65535];
  int          total = 0;
  int          bad = 0;
  int          xfers = 0;
  int          c0;

  always #5 clk = ~clk;

  assign rom_data = rom[rom_addr];

  fetch_unit #(.ADDR_WIDTH(16), .RESET_VECTOR(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_op1(instr_op1), .instr_op2(instr_op2),
    .instr_len(instr_len), .instr_pc(instr_pc)
  );

  // Completed handshakes seen by decode
  always @(posedge clk) begin
    if (!rst && instr_valid && instr_ready) xfers <= xfers + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_instr(input string tag, input logic [7:0] op, input logic [7:0] o1,
                           input logic [7:0] o2, input logic [1:0] len, input logic [15:0] pc);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd1);
    chk({tag, ".op"},    32'(instr_opcode), 32'(op));
    chk({tag, ".op1"},   32'(instr_op1), 32'(o1));
    chk({tag, ".op2"},   32'(instr_op2), 32'(o2));
    chk({tag, ".len"},   32'(instr_len), 32'(len));
    chk({tag, ".pc"},    32'(instr_pc), 32'(pc));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"},  32'(rom_addr), 32'h0000);
    chk({tag, ".valid"}, 32'(instr_valid), 32'd0);
    chk({tag, ".op"},    32'(instr_opcode), 32'd0);
    chk({tag, ".op1"},   32'(instr_op1), 32'd0);
    chk({tag, ".op2"},   32'(instr_op2), 32'd0);
    chk({tag, ".len"},   32'(instr_len), 32'd0);
    chk({tag, ".pc"},    32'(instr_pc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
    rom[0] = 8'h05; rom[1] = 8'h41; rom[2] = 8'hAA;
    rom[3] = 8'h82; rom[4] = 8'h11; rom[5] = 8'h22;
    rom[6] = 8'h00; rom[7] = 8'h45; rom[8] = 8'h99;
    rom[16'h0100] = 8'h03;
    rom[16'h0300] = 8'h01;

    // 1. reset held two cycles
    rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 16'h0000; instr_ready = 1'b1;
    tick(); tick();
    chk_reset("rst");
    rst = 1'b0;
    tick();
    chk_instr("i1", 8'h05, 8'h00, 8'h00, 2'd1, 16'h0000);

    // 2. 2-byte then 3-byte with ready high
    tick();
    chk("i1.drop", 32'(instr_valid), 32'd0);
    chk("i2.addr", 32'(rom_addr), 32'h0001);
    tick();
    chk("i2.lat1", 32'(instr_valid), 32'd0);
    tick();
    chk_instr("i2", 8'h41, 8'hAA, 8'h00, 2'd2, 16'h0001);
    tick();
    chk("i3.addr", 32'(rom_addr), 32'h0003);
    instr_ready = 1'b0;
    tick();
    chk("i3.lat1", 32'(instr_valid), 32'd0);
    tick();
    chk("i3.lat2", 32'(instr_valid), 32'd0);
    tick();
    chk_instr("i3", 8'h82, 8'h11, 8'h22, 2'd3, 16'h0003);

    // 3. backpressure for five cycles
    c0 = xfers;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_instr("bp", 8'h82, 8'h11, 8'h22, 2'd3, 16'h0003);
      chk("bp.addr", 32'(rom_addr), 32'h0006);
    end
    instr_ready = 1'b1;
    tick();
    chk("bp.xfer", 32'(xfers), 32'(c0 + 1));
    chk("bp.drop", 32'(instr_valid), 32'd0);
    chk("bp.addr2", 32'(rom_addr), 32'h0006);
    tick();
    chk_instr("i6", 8'h00, 8'h00, 8'h00, 2'd1, 16'h0006);
    tick();

    // 4. redirect while in FETCH_B1
    chk("rd.addr0", 32'(rom_addr), 32'h0007);
    tick();
    redirect_valid = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    chk("rd.valid", 32'(instr_valid), 32'd0);
    chk("rd.addr", 32'(rom_addr), 32'h0100);
    tick();
    chk_instr("rd", 8'h03, 8'h00, 8'h00, 2'd1, 16'h0100);
    tick();

    // 5. wrap across 0xFFFF
    rom[16'hFFFF] = 8'h80; rom[0] = 8'h12; rom[1] = 8'h34;
    redirect_valid = 1'b1; redirect_addr = 16'hFFFF;
    tick();
    redirect_valid = 1'b0;
    chk("wr.addr", 32'(rom_addr), 32'hFFFF);
    tick();
    chk("wr.addr1", 32'(rom_addr), 32'h0000);
    tick(); tick();
    chk_instr("wr", 8'h80, 8'h12, 8'h34, 2'd3, 16'hFFFF);
    tick();
    chk("wr.next", 32'(rom_addr), 32'h0002);

    // 6a. reset in FETCH_B2, overriding a coincident redirect
    rom[0] = 8'h05; rom[1] = 8'h41;
    tick(); tick();
    chk("rb2.valid", 32'(instr_valid), 32'd0);
    rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 16'h0200;
    tick();
    chk_reset("rb2a");
    redirect_valid = 1'b0;
    tick();
    chk_reset("rb2b");
    rst = 1'b0;
    tick();
    chk_instr("rb2", 8'h05, 8'h00, 8'h00, 2'd1, 16'h0000);

    // 6b. redirect coincident with a handshake
    c0 = xfers;
    redirect_valid = 1'b1; redirect_addr = 16'h0300;
    tick();
    redirect_valid = 1'b0;
    chk("co.xfer", 32'(xfers), 32'(c0 + 1));
    chk("co.valid", 32'(instr_valid), 32'd0);
    chk("co.addr", 32'(rom_addr), 32'h0300);
    tick();
    chk_instr("co", 8'h01, 8'h00, 8'h00, 2'd1, 16'h0300);

    // Redirect in HOLD without ready drops the held instruction
    c0 = xfers;
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'h0100;
    tick();
    redirect_valid = 1'b0; instr_ready = 1'b1;
    chk("dr.xfer", 32'(xfers), 32'(c0));
    chk("dr.valid", 32'(instr_valid), 32'd0);
    chk("dr.addr", 32'(rom_addr), 32'h0100);
    tick();
    chk_instr("dr", 8'h03, 8'h00, 8'h00, 2'd1, 16'h0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
